// File: rtl/router_pkg.sv
// Shared router definitions: flit type encoding and small decode helpers.
package router_pkg;

    typedef enum logic [1:0] {
        HEAD      = 2'b00,
        BODY      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_t;

    // Flits that open a packet and therefore have to win arbitration
    function automatic logic is_head(input logic [1:0] t);
        return (t == HEAD) || (t == HEAD_TAIL);
    endfunction

    // Flits that can only follow a granted head through a held lock
    function automatic logic is_cont(input logic [1:0] t);
        return (t == BODY) || (t == TAIL);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
    parameter int N = 5
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    // Walk the requesters starting at ptr, wrapping, and keep the first hit
    always_comb begin
        int  idx;
        logic found;
        gnt   = '0;
        idx   = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wh_xbar.sv
// Wormhole crossbar: per-output lock/owner, credit flow control and
// round-robin head arbitration, with registered outputs.
module wh_xbar
    import router_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = 32,
    parameter int CREDITS   = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_PORTS-1:0]                       i_valid,
    input  logic [NUM_PORTS-1:0][FLIT_W-1:0]           i_flit,
    input  logic [NUM_PORTS-1:0][1:0]                  i_type,
    input  logic [NUM_PORTS-1:0][$clog2(NUM_PORTS)-1:0] i_dest,
    output logic [NUM_PORTS-1:0]                       o_ready,
    output logic [NUM_PORTS-1:0]                       o_valid,
    output logic [NUM_PORTS-1:0][FLIT_W-1:0]           o_flit,
    input  logic [NUM_PORTS-1:0]                       i_credit_ret,
    output logic [NUM_PORTS-1:0]                       o_locked
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    logic [NUM_PORTS-1:0]                lock;
    logic [NUM_PORTS-1:0][PW-1:0]        owner;
    logic [NUM_PORTS-1:0][PW-1:0]        rr;
    logic [NUM_PORTS-1:0][CW-1:0]        credit;

    logic [NUM_PORTS-1:0]                owns;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;   // [output][input]
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt;   // [output][input]
    logic [NUM_PORTS-1:0]                head_xfer;
    logic [NUM_PORTS-1:0]                body_xfer;
    logic [NUM_PORTS-1:0]                tail_xfer;
    logic [NUM_PORTS-1:0]                opens_lock;
    logic [NUM_PORTS-1:0]                xfer;
    logic [NUM_PORTS-1:0][PW-1:0]        sel_idx;
    logic [NUM_PORTS-1:0][FLIT_W-1:0]    sel_flit;
    logic [NUM_PORTS-1:0]                spurious_ret;

    // Inputs holding a wormhole may not open another; the rest request by head
    always_comb begin
        owns = '0;
        req  = '0;
        for (int d = 0; d < NUM_PORTS; d++)
            for (int i = 0; i < NUM_PORTS; i++)
                if (lock[d] && owner[d] == PW'(i)) owns[i] = 1'b1;
        for (int d = 0; d < NUM_PORTS; d++)
            for (int i = 0; i < NUM_PORTS; i++)
                req[d][i] = i_valid[i] && is_head(i_type[i]) &&
                            (i_dest[i] == PW'(d)) && !owns[i];
    end

    for (genvar d = 0; d < NUM_PORTS; d++) begin : g_arb
        rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .req (req[d]),
            .ptr (rr[d]),
            .gnt (gnt[d])
        );
    end

    // Per output: locked outputs follow their owner, free ones take the arbiter winner
    always_comb begin
        o_ready    = '0;
        head_xfer  = '0;
        body_xfer  = '0;
        tail_xfer  = '0;
        opens_lock = '0;
        sel_idx    = '0;
        sel_flit   = '0;
        for (int d = 0; d < NUM_PORTS; d++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (lock[d]) begin
                    if (owner[d] == PW'(i) && i_valid[i] && is_cont(i_type[i]) &&
                        credit[d] != '0) begin
                        body_xfer[d] = 1'b1;
                        tail_xfer[d] = (i_type[i] == TAIL);
                        o_ready[i]   = 1'b1;
                        sel_flit[d]  = i_flit[i];
                    end
                end else if (gnt[d][i] && credit[d] != '0) begin
                    head_xfer[d]  = 1'b1;
                    opens_lock[d] = (i_type[i] == HEAD);
                    o_ready[i]    = 1'b1;
                    sel_idx[d]    = PW'(i);
                    sel_flit[d]   = i_flit[i];
                end
            end
        end
        if (!rst_n) o_ready = '0;
    end

    assign xfer     = head_xfer | body_xfer;
    assign o_locked = lock;

    // A return arriving with the counter already full has no slot to account for
    always_comb begin
        spurious_ret = '0;
        for (int d = 0; d < NUM_PORTS; d++)
            spurious_ret[d] = i_credit_ret[d] && !xfer[d] && (credit[d] == CMAX);
    end

    // Output registers, credit counters, lock/owner and round-robin pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock    <= '0;
            owner   <= '0;
            rr      <= '0;
            credit  <= {NUM_PORTS{CMAX}};
            o_valid <= '0;
            o_flit  <= '0;
        end else begin
            for (int d = 0; d < NUM_PORTS; d++) begin
                o_valid[d] <= xfer[d];
                if (xfer[d]) o_flit[d] <= sel_flit[d];

                if (xfer[d] && !i_credit_ret[d])
                    credit[d] <= credit[d] - CW'(1);
                else if (!xfer[d] && i_credit_ret[d] && credit[d] != CMAX)
                    credit[d] <= credit[d] + CW'(1);

                if (head_xfer[d]) begin
                    rr[d] <= (sel_idx[d] == PW'(NUM_PORTS - 1)) ? '0 : sel_idx[d] + PW'(1);
                    if (opens_lock[d]) begin
                        lock[d]  <= 1'b1;
                        owner[d] <= sel_idx[d];
                    end
                end
                if (body_xfer[d] && tail_xfer[d]) lock[d] <= 1'b0;
            end
        end
    end

    // Flag downstream over-reporting free slots; the counter saturates instead
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (spurious_ret == '0)
                else $warning("wh_xbar: credit return with counter full, outputs %b", spurious_ret);
        end
    end

endmodule

// File: tb/tb_wh_xbar.sv
// Bench for wh_xbar: directed packet scenarios followed by random traffic,
// every cycle compared with a packet-level reference model.
module tb_wh_xbar;
    import router_pkg::*;

    localparam int N  = 5;
    localparam int FW = 32;
    localparam int CR = 4;
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(CR + 1);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [N-1:0]          iv, iret, o_ready, o_valid, o_locked;
    logic [N-1:0][FW-1:0]  iflit, o_flit;
    logic [N-1:0][1:0]     ity;
    logic [N-1:0][PW-1:0]  idest;

    int total = 0;
    int bad   = 0;
    int passed;

    // reference state per output
    bit          m_lock[N];
    int          m_owner[N];
    int          m_rr[N];
    int          m_cred[N];
    bit          m_ov[N];
    logic [FW-1:0] m_of[N];

    always #5 clk = ~clk;

    wh_xbar #(.NUM_PORTS(N), .FLIT_W(FW), .CREDITS(CR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (iv),
        .i_flit       (iflit),
        .i_type       (ity),
        .i_dest       (idest),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_flit       (o_flit),
        .i_credit_ret (iret),
        .o_locked     (o_locked)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_lock[d] = 0; m_owner[d] = 0; m_rr[d] = 0;
            m_cred[d] = CR; m_ov[d] = 0; m_of[d] = '0;
        end
    endtask

    function automatic logic [N*CW-1:0] full_credits();
        logic [N-1:0][CW-1:0] v;
        for (int d = 0; d < N; d++) v[d] = CW'(CR);
        return v;
    endfunction

    task automatic idle();
        iv = '0;
        iret = '0;
    endtask

    task automatic put(input int i, input flit_type_t t, input int d, input logic [FW-1:0] f);
        iv[i]    = 1'b1;
        ity[i]   = t;
        idest[i] = PW'(d);
        iflit[i] = f;
    endtask

    // One clock: predict acceptance from the packet rules, then the registered result
    task automatic cycle(input string tag);
        logic [N-1:0] er, ex, es, ev, el;
        logic [N-1:0][CW-1:0] ec;
        int  src[N];
        bit  own[N];
        er = '0; ex = '0; es = '0;
        for (int i = 0; i < N; i++) own[i] = 0;
        for (int d = 0; d < N; d++) begin
            src[d] = 0;
            if (m_lock[d]) own[m_owner[d]] = 1;
        end
        for (int d = 0; d < N; d++) begin
            if (m_lock[d]) begin
                int o = m_owner[d];
                if (iv[o] && (ity[o] == BODY || ity[o] == TAIL) && m_cred[d] > 0) begin
                    er[o] = 1; ex[d] = 1; src[d] = o;
                end
            end else if (m_cred[d] > 0) begin
                for (int k = 0; k < N; k++) begin
                    int i = (m_rr[d] + k) % N;
                    if (iv[i] && (ity[i] == HEAD || ity[i] == HEAD_TAIL) &&
                        int'(idest[i]) == d && !own[i]) begin
                        er[i] = 1; ex[d] = 1; src[d] = i;
                        break;
                    end
                end
            end
            es[d] = iret[d] && !ex[d] && m_cred[d] == CR;
        end
        #1;
        chk({tag, " ready"}, 64'(o_ready), 64'(er));
        chk({tag, " spurious"}, 64'(dut.spurious_ret), 64'(es));
        @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            if (ex[d]) begin
                m_ov[d] = 1;
                m_of[d] = iflit[src[d]];
                if (m_lock[d]) begin
                    if (ity[src[d]] == TAIL) m_lock[d] = 0;
                end else begin
                    m_rr[d] = (src[d] + 1) % N;
                    if (ity[src[d]] == HEAD) begin
                        m_lock[d] = 1; m_owner[d] = src[d];
                    end
                end
            end else begin
                m_ov[d] = 0;
            end
            if (ex[d] && !iret[d]) m_cred[d]--;
            else if (!ex[d] && iret[d] && m_cred[d] < CR) m_cred[d]++;
            ev[d] = m_ov[d];
            el[d] = m_lock[d];
            ec[d] = CW'(m_cred[d]);
        end
        chk({tag, " o_valid"}, 64'(o_valid), 64'(ev));
        chk({tag, " o_locked"}, 64'(o_locked), 64'(el));
        chk({tag, " credit"}, 64'(dut.credit), 64'(ec));
        for (int d = 0; d < N; d++)
            chk($sformatf("%s o_flit[%0d]", tag, d), 64'(o_flit[d]), 64'(m_of[d]));
    endtask

    task automatic do_reset();
        idle();
        put(0, HEAD, 0, 32'hDEAD_0000);
        rst_n = 1'b0;
        #1;
        chk("reset ready", 64'(o_ready), 64'(0));
        chk("reset o_valid", 64'(o_valid), 64'(0));
        chk("reset o_locked", 64'(o_locked), 64'(0));
        chk("reset credit", 64'(dut.credit), 64'(full_credits()));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        model_reset();
    endtask

    initial begin
        iv = '0; iret = '0; iflit = '0; ity = '0; idest = '0;
        @(posedge clk);
        #1;

        // packet through output 2 from input 0
        do_reset();
        put(0, HEAD, 2, 32'hA000_0001); cycle("s1 head");
        chk("s1 valid c1", 64'(o_valid[2]), 64'(1));
        put(0, BODY, 2, 32'hA000_0002); cycle("s1 body");
        chk("s1 valid c2", 64'(o_valid[2]), 64'(1));
        put(0, TAIL, 2, 32'hA000_0003); cycle("s1 tail");
        chk("s1 valid c3", 64'(o_valid[2]), 64'(1));
        chk("s1 flit c3", 64'(o_flit[2]), 64'(32'hA000_0003));
        chk("s1 unlocked", 64'(o_locked[2]), 64'(0));
        idle(); cycle("s1 idle");
        chk("s1 credit", 64'(dut.credit[2]), 64'(1));

        // three heads race for output 0
        do_reset();
        put(1, HEAD, 0, 32'hB100_0001);
        put(3, HEAD, 0, 32'hB300_0001);
        put(4, HEAD, 0, 32'hB400_0001);
        #1; chk("s2 first grant", 64'(o_ready), 64'(5'b00010));
        cycle("s2 c1");
        put(1, TAIL, 0, 32'hB100_0002); iret[0] = 1'b1; cycle("s2 c2");
        iv[1] = 1'b0;
        #1; chk("s2 second grant", 64'(o_ready), 64'(5'b01000));
        cycle("s2 c3");
        put(3, TAIL, 0, 32'hB300_0002); cycle("s2 c4");
        iv[3] = 1'b0;
        #1; chk("s2 third grant", 64'(o_ready), 64'(5'b10000));
        cycle("s2 c5");
        put(4, TAIL, 0, 32'hB400_0002); cycle("s2 c6");
        chk("s2 unlocked", 64'(o_locked[0]), 64'(0));
        idle(); cycle("s2 idle");

        // credit starvation on output 1 with two credits left
        do_reset();
        put(0, HEAD_TAIL, 1, 32'hC000_0001); cycle("s3 drain1");
        put(0, HEAD_TAIL, 1, 32'hC000_0002); cycle("s3 drain2");
        iv[0] = 1'b0;
        chk("s3 start credit", 64'(dut.credit[1]), 64'(2));
        passed = 0;
        put(2, HEAD, 1, 32'hC200_0001); cycle("s3 head"); passed += int'(o_valid[1]);
        put(2, BODY, 1, 32'hC200_0002); cycle("s3 body1"); passed += int'(o_valid[1]);
        put(2, BODY, 1, 32'hC200_0003);
        #1; chk("s3 stall ready", 64'(o_ready[2]), 64'(0));
        cycle("s3 stall1"); passed += int'(o_valid[1]);
        cycle("s3 stall2"); passed += int'(o_valid[1]);
        chk("s3 lock held", 64'(o_locked[1]), 64'(1));
        iret[1] = 1'b1; cycle("s3 return"); passed += int'(o_valid[1]);
        iret[1] = 1'b0;
        #1; chk("s3 resume ready", 64'(o_ready[2]), 64'(1));
        cycle("s3 body2"); passed += int'(o_valid[1]);
        chk("s3 body2 flit", 64'(o_flit[1]), 64'(32'hC200_0003));
        put(2, TAIL, 1, 32'hC200_0004);
        #1; chk("s3 tail stalled", 64'(o_ready[2]), 64'(0));
        cycle("s3 tail wait"); passed += int'(o_valid[1]);
        chk("s3 flits passed", 64'(passed), 64'(3));
        chk("s3 lock kept", 64'(o_locked[1]), 64'(1));

        // back-to-back single-flit packets to output 3
        do_reset();
        put(0, HEAD_TAIL, 3, 32'hD000_0001); cycle("s4 p0");
        chk("s4 p0 lock", 64'(o_locked[3]), 64'(0));
        iv[0] = 1'b0;
        put(1, HEAD_TAIL, 3, 32'hD100_0001);
        #1; chk("s4 p1 ready", 64'(o_ready), 64'(5'b00010));
        cycle("s4 p1");
        chk("s4 p1 valid", 64'(o_valid[3]), 64'(1));
        chk("s4 p1 flit", 64'(o_flit[3]), 64'(32'hD100_0001));
        chk("s4 p1 lock", 64'(o_locked[3]), 64'(0));
        idle(); cycle("s4 idle");

        // simultaneous transfer and return, then a return with nothing owed
        do_reset();
        put(0, HEAD_TAIL, 4, 32'hE000_0001); cycle("s5 take");
        put(0, HEAD_TAIL, 4, 32'hE000_0002); iret[4] = 1'b1; cycle("s5 both");
        chk("s5 credit both", 64'(dut.credit[4]), 64'(CR - 1));
        iv[0] = 1'b0; cycle("s5 refill");
        #1; chk("s5 spurious flag", 64'(dut.spurious_ret[4]), 64'(1));
        cycle("s5 spurious");
        chk("s5 credit sat", 64'(dut.credit[4]), 64'(CR));
        idle(); cycle("s5 idle");

        // reset lands in the middle of a packet
        do_reset();
        put(0, HEAD, 2, 32'hF000_0001); cycle("s6 head");
        put(0, BODY, 2, 32'hF000_0002); cycle("s6 body");
        rst_n = 1'b0;
        #1;
        chk("s6 o_valid", 64'(o_valid), 64'(0));
        chk("s6 o_locked", 64'(o_locked), 64'(0));
        chk("s6 o_flit", 64'(|o_flit), 64'(0));
        chk("s6 credit", 64'(dut.credit), 64'(full_credits()));
        chk("s6 ready in reset", 64'(o_ready), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #1; chk("s6 orphan body", 64'(o_ready[0]), 64'(0));
        cycle("s6 after");
        idle(); cycle("s6 idle");

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                iv[i]    = ($urandom_range(0, 3) != 0);
                ity[i]   = 2'($urandom_range(0, 3));
                idest[i] = PW'($urandom_range(0, N - 1));
                iflit[i] = $urandom;
            end
            for (int d = 0; d < N; d++)
                iret[d] = (m_cred[d] < CR) && ($urandom_range(0, 2) == 0);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wh_xbar.md
WH_XBAR -- requirements
Module: wh_xbar

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, number of input and output ports (2..8).
REQ-002 SHALL have parameter FLIT_W, default 32, flit payload width in bits.
REQ-003 SHALL have parameter CREDITS, default 4, downstream buffer depth per output (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_valid  input  [NUM_PORTS]  per input: flit present.
REQ-007 SHALL have port i_flit  input  [NUM_PORTS][FLIT_W]  per input: payload.
REQ-008 SHALL have port i_type  input  [NUM_PORTS][2]  per input: flit_type_t (HEAD, BODY, TAIL, HEAD_TAIL).
REQ-009 SHALL have port i_dest  input  [NUM_PORTS][$clog2(NUM_PORTS)]  per input: target output; sampled on HEAD/HEAD_TAIL only.
REQ-010 SHALL have port o_ready  output  [NUM_PORTS]  per input: flit consumed this cycle (combinational).
REQ-011 SHALL have port o_valid  output  [NUM_PORTS]  per output: registered flit valid.
REQ-012 SHALL have port o_flit  output  [NUM_PORTS][FLIT_W]  per output: registered payload.
REQ-013 SHALL have port i_credit_ret  input  [NUM_PORTS]  per output: one downstream slot freed.
REQ-014 SHALL have port o_locked  output  [NUM_PORTS]  per output: wormhole lock held (status).

Function
REQ-015 SHALL hold, per output d, lock[d], owner[d] (input index), credit[d] (0..CREDITS) and round-robin pointer rr[d].
REQ-016 SHALL treat input i as requesting output d when i_valid[i], i_type[i] is HEAD or HEAD_TAIL, i_dest[i]==d, and input i owns no output.
REQ-017 SHALL grant free output d (lock[d]==0) only when credit[d]>0, to the first requester at or after rr[d] in ascending index order, wrapping modulo NUM_PORTS.
REQ-018 SHALL transfer the granted head flit in the grant cycle: o_ready[i]=1.
REQ-019 SHALL set lock[d]=1 and owner[d]=i on a HEAD grant, and set rr[d]=(i+1) mod NUM_PORTS.
REQ-020 SHALL NOT set lock on a HEAD_TAIL grant; rr[d] still advances.
REQ-021 SHALL, while lock[d]==1, transfer BODY/TAIL from owner[d] when i_valid asserted and credit[d]>0; no other input is granted d.
REQ-022 SHALL clear lock[d] at the clock edge of the TAIL transfer; d is arbitrable from the next cycle.
REQ-023 SHALL hold o_ready[i]=0 for a BODY/TAIL on an input that owns no output (protocol error), and for a HEAD on an input that already owns an output.
REQ-024 SHALL register each transfer: o_valid[d]=1 and o_flit[d]=flit one cycle after o_ready; otherwise o_valid[d]=0 and o_flit[d] holds its value.
REQ-025 SHALL update credit[d]: -1 on transfer, +1 on i_credit_ret[d], unchanged if both occur in the same cycle.
REQ-026 SHALL saturate credit[d] at CREDITS on a spurious return; the RTL SHALL carry an assertion that flags it.
REQ-027 SHALL stall on credit[d]==0: the owner's o_ready stays 0 and the lock is held.
REQ-028 SHALL allow different outputs to transfer concurrently, each from a distinct input (full crossbar).
REQ-029 SHALL drive o_locked[d]=lock[d].

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear lock, owner, rr, o_valid and o_flit to 0, and set every credit[d] to CREDITS.
REQ-031 SHALL discard in-flight packets when reset is asserted mid-packet; after release, BODY/TAIL on unlocked inputs are refused per REQ-023.
REQ-032 SHALL hold o_ready at 0 while rst_n is low.

Structure
REQ-033 SHALL define flit_type_t and its encoding (HEAD=00, BODY=01, TAIL=10, HEAD_TAIL=11) in router_pkg.
REQ-034 SHALL instantiate one rr_arbiter sub-module per output (parameter N, inputs req and ptr, output one-hot gnt).

Verification
REQ-035 SHALL cover: reset, then input 0 sends HEAD/BODY/TAIL to output 2 with CREDITS=4 -> o_valid[2] high on cycles 1..3 after the first o_ready, o_locked[2] low after TAIL, credit[2]=1.
REQ-036 SHALL cover: inputs 1, 3 and 4 send HEAD to output 0 in the same cycle with rr[0]=0 -> grant order 1, then 3, then 4, each after the prior TAIL.
REQ-037 SHALL cover: CREDITS=2, no returns, 4-flit packet -> 2 flits pass, the owner stalls with the lock held; one i_credit_ret -> exactly one more flit passes.
REQ-038 SHALL cover: HEAD_TAIL from inputs 0 and 1 to output 3 on consecutive cycles -> both delivered back-to-back, o_locked[3] never high.
REQ-039 SHALL cover: transfer and i_credit_ret in the same cycle at credit=CREDITS-1 -> credit unchanged; a return at credit=CREDITS -> credit stays CREDITS and the assertion fires.
REQ-040 SHALL cover: rst_n pulsed low mid-packet -> outputs clear immediately, credits=CREDITS, the following BODY gets o_ready=0.
